// File: rtl/vga_pkg.sv
// Shared constants and types for the text-mode VRAM port-A write path.
// The optional scroll register is enabled by defining VRAM_SCROLL_EN.
package vga_pkg;

   localparam int COLS          = 32;
   localparam int ROWS          = 30;
   localparam int CELLS         = COLS * ROWS;
   localparam int ADDR_W        = 10;
   localparam int CHAR_W        = 8;
   localparam int ROW_W         = 5;
   localparam int WR_FIFO_DEPTH = 4;

   localparam logic CTRL0_SEL     = 1'b0;
   localparam logic CTRL1_SEL     = 1'b1;
   localparam int   CLR_START_BIT = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   // Rows past the last visible one clamp to the last row.
   function automatic logic [ROW_W-1:0] sat_row(input logic [ROW_W-1:0] r);
      return (r >= ROW_W'(ROWS)) ? ROW_W'(ROWS - 1) : r;
   endfunction

endpackage

// File: rtl/vram_write_ctrl_if.sv
// CPU-side write bus into the VRAM write controller (strobe, address, data, busy).
interface vram_write_ctrl_if
   import vga_pkg::*;
#(
   parameter int AW = ADDR_W
);
   logic          cpu_we;
   logic [AW:0]   cpu_addr;
   logic [31:0]   cpu_data;
   logic          cpu_busy;

   modport master (output cpu_we, cpu_addr, cpu_data, input cpu_busy);
   modport slave  (input cpu_we, cpu_addr, cpu_data, output cpu_busy);
endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO for posted cell writes; head is readable combinationally.
module vram_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q;
   logic [PW:0]      rd_ptr_q;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
   end

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign data_o  = mem_q[rd_ptr_q[PW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
endmodule

// File: rtl/vram_write_ctrl.sv
// VRAM port-A owner: posted CPU cell writes plus a full-screen fill engine.
// Define VRAM_SCROLL_EN to add the CTRL1 scroll_row register.
module vram_write_ctrl (
   input  logic                        clk_50mhz,
   input  logic                        rst,
   vram_write_ctrl_if.slave            bus,
   output logic                        clr_busy,
   output logic                        ovf,
   output logic                        vm_we,
   output logic [vga_pkg::ADDR_W-1:0]  vm_addr,
   output logic [vga_pkg::CHAR_W-1:0]  vm_din,
   output logic [vga_pkg::ROW_W-1:0]   scroll_row
);
   import vga_pkg::*;

   localparam int FW = ADDR_W + CHAR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CHAR_W-1:0] fill_q, fill_d;
   logic              ovf_q, ovf_d;
   logic              vm_we_q, vm_we_d;
   logic [ADDR_W-1:0] vm_addr_q, vm_addr_d;
   logic [CHAR_W-1:0] vm_din_q, vm_din_d;

   logic              cell_wr, ctrl_wr, clr_start;
   logic              fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]     fifo_head;
   logic              unused_data_bits;

   assign cell_wr   = bus.cpu_we & ~bus.cpu_addr[ADDR_W];
   assign ctrl_wr   = bus.cpu_we &  bus.cpu_addr[ADDR_W];
   assign clr_start = ctrl_wr & (bus.cpu_addr[0] == CTRL0_SEL) & bus.cpu_data[CLR_START_BIT];
   // A clear start wins over draining: the queued entries are being discarded.
   assign fifo_pop  = (state_q == IDLE) & ~fifo_empty & ~clr_start;
   assign unused_data_bits = ^bus.cpu_data[31:CLR_START_BIT+1];

   vram_wr_fifo #(
      .DEPTH (WR_FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk_50mhz),
      .rst     (rst),
      .flush_i (clr_start),
      .push_i  (cell_wr),
      .data_i  ({bus.cpu_addr[ADDR_W-1:0], bus.cpu_data[CHAR_W-1:0]}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      fill_d    = fill_q;
      ovf_d     = ovf_q | (cell_wr & fifo_full);
      vm_we_d   = 1'b0;
      vm_addr_d = vm_addr_q;
      vm_din_d  = vm_din_q;
      case (state_q)
         IDLE: begin
            if (fifo_pop) begin
               vm_we_d   = 1'b1;
               vm_addr_d = fifo_head[FW-1:CHAR_W];
               vm_din_d  = fifo_head[CHAR_W-1:0];
            end
         end
         CLEAR: begin
            vm_we_d   = 1'b1;
            vm_addr_d = ptr_q;
            vm_din_d  = fill_q;
            if (ptr_q == ADDR_W'(CELLS - 1)) state_d = IDLE;
            else                             ptr_d   = ptr_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (clr_start) begin
         state_d = CLEAR;
         ptr_d   = '0;
         fill_d  = bus.cpu_data[CHAR_W-1:0];
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         fill_q    <= '0;
         ovf_q     <= 1'b0;
         vm_we_q   <= 1'b0;
         vm_addr_q <= '0;
         vm_din_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         fill_q    <= fill_d;
         ovf_q     <= ovf_d;
         vm_we_q   <= vm_we_d;
         vm_addr_q <= vm_addr_d;
         vm_din_q  <= vm_din_d;
      end
   end

   assign clr_busy     = (state_q == CLEAR);
   assign bus.cpu_busy = fifo_full | clr_busy;
   assign ovf          = ovf_q;
   assign vm_we        = vm_we_q;
   assign vm_addr      = vm_addr_q;
   assign vm_din       = vm_din_q;

`ifdef VRAM_SCROLL_EN
   logic [ROW_W-1:0] scroll_q, scroll_d;
   logic             scroll_wr;

   assign scroll_wr = ctrl_wr & (bus.cpu_addr[0] == CTRL1_SEL);

   always_comb begin
      scroll_d = scroll_q;
      if (clr_start)      scroll_d = '0;
      else if (scroll_wr) scroll_d = sat_row(bus.cpu_data[ROW_W-1:0]);
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) scroll_q <= '0;
      else     scroll_q <= scroll_d;
   end

   assign scroll_row = scroll_q;
`else
   assign scroll_row = '0;
`endif
endmodule

// File: tb/tb_vram_write_ctrl.sv
// Directed self-checking bench for vram_write_ctrl (both VRAM_SCROLL_EN builds).
module tb_vram_write_ctrl;

   logic       clk_50mhz = 1'b0;
   logic       rst;
   logic       clr_busy;
   logic       ovf;
   logic       vm_we;
   logic [9:0] vm_addr;
   logic [7:0] vm_din;
   logic [4:0] scroll_row;

   int total = 0;
   int bad   = 0;

   vram_write_ctrl_if #(.AW(10)) bus ();

   vram_write_ctrl dut (
      .clk_50mhz  (clk_50mhz),
      .rst        (rst),
      .bus        (bus),
      .clr_busy   (clr_busy),
      .ovf        (ovf),
      .vm_we      (vm_we),
      .vm_addr    (vm_addr),
      .vm_din     (vm_din),
      .scroll_row (scroll_row)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // Write-port monitor: each cycle is labelled by ncyc, sampled mid-cycle.
   int         ncyc     = 0;
   int         busy_cnt = 0;
   logic [9:0] cap_addr [$];
   logic [7:0] cap_din  [$];
   int         cap_cyc  [$];

   always @(negedge clk_50mhz) begin
      if (vm_we) begin
         cap_addr.push_back(vm_addr);
         cap_din.push_back(vm_din);
         cap_cyc.push_back(ncyc);
      end
      if (clr_busy) busy_cnt++;
      ncyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50mhz);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_wr(input logic [10:0] a, input logic [31:0] d);
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_data = d;
      $display("bus write addr=%03h data=%08h", a, d);
      tick();
      bus.cpu_we   = 1'b0;
   endtask

   int base, s, b0, n, errs, j, zeros, stray, found;

   initial begin
      rst          = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_data = '0;
      ticks(3);
      rst = 1'b0;
      tick();
      chk("rst_vm_we", vm_we, 0);
      chk("rst_vm_addr", vm_addr, 0);
      chk("rst_vm_din", vm_din, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_cpu_busy", bus.cpu_busy, 0);
      chk("rst_scroll", scroll_row, 0);

      // Single cell write: visible on port A two cycles later, for one cycle.
      bus_wr(11'h005, 32'h41);
      chk("t1_n1_we", vm_we, 0);
      tick();
      chk("t1_n2_we", vm_we, 1);
      chk("t1_n2_addr", vm_addr, 10'h005);
      chk("t1_n2_din", vm_din, 8'h41);
      tick();
      chk("t1_n3_we", vm_we, 0);
      chk("t1_n3_addr_hold", vm_addr, 10'h005);
      chk("t1_n3_din_hold", vm_din, 8'h41);

      // CTRL0 without the start bit does nothing.
      base = cap_addr.size();
      bus_wr(11'h400, 32'h055);
      chk("noclr_busy", clr_busy, 0);
      ticks(3);
      chk("noclr_writes", cap_addr.size() - base, 0);

      // Full clear with 0x20.
      base = cap_addr.size();
      b0   = busy_cnt;
      s    = ncyc;
      bus_wr(11'h400, 32'h120);
      chk("t3_busy_n1", clr_busy, 1);
      chk("t3_cpu_busy_n1", bus.cpu_busy, 1);
      ticks(1000);
      n = cap_addr.size() - base;
      chk("t3_count", n, 960);
      chk("t3_busy_cycles", busy_cnt - b0, 960);
      errs = 0;
      for (int i = 0; i < n; i++)
         if (cap_addr[base+i] != 10'(i) || cap_din[base+i] != 8'h20 || cap_addr[base+i] >= 10'd960) errs++;
      chk("t3_seq_errs", errs, 0);
      if (n > 0) begin
         chk("t3_first_cycle", cap_cyc[base] - s, 2);
         chk("t3_span", cap_cyc[base+n-1] - cap_cyc[base], 959);
         chk("t3_last_addr", cap_addr[base+n-1], 959);
      end

      // Five writes during a clear: four queue, fifth drops.
      base = cap_addr.size();
      bus_wr(11'h400, 32'h1AA);
      for (int i = 0; i < 5; i++) bus_wr(11'h010 + 11'(i), 32'h51 + 32'(i));
      chk("t2_ovf", ovf, 1);
      chk("t2_cpu_busy", bus.cpu_busy, 1);
      found = 0;
      for (int i = 0; i < 1100 && found == 0; i++) begin
         if (!clr_busy) found = 1;
         else tick();
      end
      chk("t2_clear_end", found, 1);
      chk("t2_full_busy", bus.cpu_busy, 1);
      ticks(20);
      chk("t2_idle_busy", bus.cpu_busy, 0);
      chk("t2_ovf_sticky", ovf, 1);
      n = cap_addr.size() - base;
      chk("t2_count", n, 964);
      if (n >= 964) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_q%0d_addr", k), cap_addr[base+960+k], 10'h010 + 10'(k));
            chk($sformatf("t2_q%0d_din", k), cap_din[base+960+k], 8'h51 + 8'(k));
         end
         chk("t2_q_span", cap_cyc[base+963] - cap_cyc[base+959], 4);
      end

      // Queued writes are flushed by a clear restart with fill 0x00.
      base = cap_addr.size();
      bus_wr(11'h400, 32'h1BB);
      for (int i = 0; i < 3; i++) bus_wr(11'h020 + 11'(i), 32'h61 + 32'(i));
      s = ncyc;
      bus_wr(11'h400, 32'h100);
      ticks(1100);
      n = cap_addr.size() - base;
      j = -1; zeros = 0; stray = 0; errs = 0;
      for (int i = 0; i < n; i++) begin
         if (cap_din[base+i] >= 8'h61 && cap_din[base+i] <= 8'h63) stray++;
         if (cap_din[base+i] == 8'h00) begin
            if (j < 0) j = i;
            if (cap_addr[base+i] != 10'(zeros)) errs++;
            zeros++;
         end
      end
      chk("t4_stray", stray, 0);
      chk("t4_zero_count", zeros, 960);
      chk("t4_zero_seq_errs", errs, 0);
      chk("t4_restart_found", (j >= 0), 1);
      if (j >= 0) begin
         chk("t4_restart_cycle", cap_cyc[base+j] - s, 2);
         chk("t4_tail", n - j, 960);
      end

      // Reset in the middle of a clear aborts it.
      base = cap_addr.size();
      bus_wr(11'h400, 32'h12E);
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (vm_we && vm_addr == 10'd99) found = 1;
         else tick();
      end
      chk("t5_reach_99", found, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_clr_busy", clr_busy, 0);
      chk("t5_vm_we", vm_we, 0);
      chk("t5_ovf", ovf, 0);
      chk("t5_cpu_busy", bus.cpu_busy, 0);
      n = cap_addr.size() - base;
      chk("t5_writes_before", n, 100);
      ticks(50);
      chk("t5_writes_after", cap_addr.size() - base, n);

`ifdef VRAM_SCROLL_EN
      bus_wr(11'h401, 32'd7);
      chk("t6_scroll7", scroll_row, 7);
      bus_wr(11'h401, 32'd31);
      chk("t6_scroll31", scroll_row, 29);
      bus_wr(11'h401, 32'd30);
      chk("t6_scroll30", scroll_row, 29);
      bus_wr(11'h401, 32'd12);
      chk("t6_scroll12", scroll_row, 12);
      bus_wr(11'h400, 32'h120);
      chk("t6_scroll_clr", scroll_row, 0);
      ticks(1000);
`else
      bus_wr(11'h401, 32'd7);
      chk("t6_scroll_off", scroll_row, 0);
      chk("t6_no_clear", clr_busy, 0);
      ticks(2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
